// File: rtl/cntl_pkg.sv
// Shared definitions for the 4-register/ALU/shifter datapath controllers:
// state codes, ALU opcodes, shifter controls and register indices.
package cntl_pkg;

  // DONE takes the fourth bit so that it cannot alias any loop state
  typedef enum logic [3:0] {
    ST_IDLE = 4'b0000,
    ST_LDA  = 4'b0001,
    ST_LDB  = 4'b0010,
    ST_CLR  = 4'b0011,
    ST_TEST = 4'b0100,
    ST_ADD  = 4'b0101,
    ST_SHA  = 4'b0110,
    ST_SHB  = 4'b0111,
    ST_DONE = 4'b1000
  } state_t;

  localparam logic [2:0] ALU_PASSA = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_XOR   = 3'b101;

  localparam logic [1:0] SH_NONE  = 2'b00;
  localparam logic [1:0] SH_LEFT  = 2'b01;
  localparam logic [1:0] SH_RIGHT = 2'b10;

  localparam logic [1:0] REG_A = 2'd0;
  localparam logic [1:0] REG_B = 2'd1;
  localparam logic [1:0] REG_P = 2'd2;

endpackage

// File: rtl/mult_cw_decode.sv
// Combinational state -> control-word decoder for the shift-add multiplier.
// Unused and illegal state codes decode to an all-zero control word.
module mult_cw_decode
  import cntl_pkg::*;
(
  input  state_t     state,
  output logic       IE,
  output logic       WE,
  output logic [1:0] WA,
  output logic       RAE,
  output logic [1:0] RAA,
  output logic       RBE,
  output logic [1:0] RBA,
  output logic [2:0] ALU,
  output logic [1:0] SH,
  output logic       OE,
  output logic       busy,
  output logic       done
);

  always_comb begin
    IE   = 1'b0;
    WE   = 1'b0;
    WA   = REG_A;
    RAE  = 1'b0;
    RAA  = REG_A;
    RBE  = 1'b0;
    RBA  = REG_A;
    ALU  = ALU_PASSA;
    SH   = SH_NONE;
    OE   = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_LDA: begin
        IE = 1'b1; WE = 1'b1; WA = REG_A; busy = 1'b1;
      end
      ST_LDB: begin
        IE = 1'b1; WE = 1'b1; WA = REG_B; busy = 1'b1;
      end
      // P xor P clears the product without needing a constant source
      ST_CLR: begin
        WE = 1'b1; WA = REG_P; RAE = 1'b1; RAA = REG_P;
        RBE = 1'b1; RBA = REG_P; ALU = ALU_XOR; busy = 1'b1;
      end
      ST_TEST: begin
        RAE = 1'b1; RAA = REG_B; ALU = ALU_PASSA; busy = 1'b1;
      end
      ST_ADD: begin
        WE = 1'b1; WA = REG_P; RAE = 1'b1; RAA = REG_P;
        RBE = 1'b1; RBA = REG_A; ALU = ALU_ADD; busy = 1'b1;
      end
      ST_SHA: begin
        WE = 1'b1; WA = REG_A; RAE = 1'b1; RAA = REG_A;
        ALU = ALU_PASSA; SH = SH_LEFT; busy = 1'b1;
      end
      ST_SHB: begin
        WE = 1'b1; WA = REG_B; RAE = 1'b1; RAA = REG_B;
        ALU = ALU_PASSA; SH = SH_RIGHT; busy = 1'b1;
      end
      ST_DONE: begin
        RAE = 1'b1; RAA = REG_P; ALU = ALU_PASSA; OE = 1'b1; done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_cntl.sv
// Moore controller sequencing the shared datapath through an unsigned
// shift-add multiply. Define MULT_EARLY_EXIT_EN to stop once the shifted B is 0.
module mult_cntl
  import cntl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       restart,
  input  logic       nEqZero,
  input  logic       lsb,
  output logic       IE,
  output logic       WE,
  output logic [1:0] WA,
  output logic       RAE,
  output logic [1:0] RAA,
  output logic       RBE,
  output logic [1:0] RBA,
  output logic [2:0] ALU,
  output logic [1:0] SH,
  output logic       OE,
  output logic       busy,
  output logic       done
);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             shb_exit;

`ifdef MULT_EARLY_EXIT_EN
  assign shb_exit = (cnt == CNT_W'(1)) || nEqZero;
`else
  logic unused_neq_zero;
  assign unused_neq_zero = nEqZero;
  assign shb_exit        = (cnt == CNT_W'(1));
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Loaded in CLR and only consumed in SHB, so it never has to wrap
  always_ff @(posedge clk) begin
    if (reset)                cnt <= '0;
    else if (state == ST_CLR) cnt <= CNT_W'(WIDTH);
    else if (state == ST_SHB) cnt <= cnt - CNT_W'(1);
  end

  always_comb begin
    next_state = ST_IDLE;
    case (state)
      ST_IDLE: next_state = start ? ST_LDA : ST_IDLE;
      ST_LDA:  next_state = ST_LDB;
      ST_LDB:  next_state = ST_CLR;
      ST_CLR:  next_state = ST_TEST;
      ST_TEST: next_state = lsb ? ST_ADD : ST_SHA;
      ST_ADD:  next_state = ST_SHA;
      ST_SHA:  next_state = ST_SHB;
      ST_SHB:  next_state = shb_exit ? ST_DONE : ST_TEST;
      ST_DONE: next_state = restart ? ST_IDLE : ST_DONE;
      default: next_state = ST_IDLE;
    endcase
  end

  mult_cw_decode u_decode (
    .state (state),
    .IE    (IE),
    .WE    (WE),
    .WA    (WA),
    .RAE   (RAE),
    .RAA   (RAA),
    .RBE   (RBE),
    .RBA   (RBA),
    .ALU   (ALU),
    .SH    (SH),
    .OE    (OE),
    .busy  (busy),
    .done  (done)
  );

endmodule

// File: tb/tb_mult_cntl.sv
// Bench for mult_cntl: a behavioural 4-register datapath closes the loop,
// and a scoreboard holds the expected product, latency and ADD count per run.
module tb_mult_cntl;

  localparam int WIDTH = 8;
`ifdef MULT_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam int S_IDLE = 0, S_LDA = 1, S_LDB = 2, S_CLR = 3, S_TEST = 4,
                 S_ADD = 5, S_SHA = 6, S_SHB = 7, S_DONE = 8;

  logic       clk = 1'b0;
  logic       reset, start, restart;
  logic       nEqZero, lsb;
  logic       IE, WE, RAE, RBE, OE, busy, done;
  logic [1:0] WA, RAA, RBA, SH;
  logic [2:0] ALU;

  always #5 clk = ~clk;

  mult_cntl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .restart(restart),
    .nEqZero(nEqZero), .lsb(lsb),
    .IE(IE), .WE(WE), .WA(WA), .RAE(RAE), .RAA(RAA), .RBE(RBE), .RBA(RBA),
    .ALU(ALU), .SH(SH), .OE(OE), .busy(busy), .done(done)
  );

  // Behavioural datapath: register file, ALU, shifter, input and output bus
  logic [7:0] rf [4];
  logic [7:0] op_a, op_b, in_bus, rd_a, rd_b, alu_y, sh_y, dp_out;

  assign in_bus = (WA == 2'd0) ? op_a : op_b;
  assign rd_a   = RAE ? rf[RAA] : 8'h00;
  assign rd_b   = RBE ? rf[RBA] : 8'h00;

  always_comb begin
    alu_y = 8'h00;
    case (ALU)
      3'b000:  alu_y = rd_a;
      3'b001:  alu_y = rd_a + rd_b;
      3'b101:  alu_y = rd_a ^ rd_b;
      default: alu_y = 8'h00;
    endcase
    sh_y = alu_y;
    if (SH == 2'b01)      sh_y = alu_y << 1;
    else if (SH == 2'b10) sh_y = alu_y >> 1;
  end

  assign nEqZero = (sh_y == 8'h00);
  assign lsb     = alu_y[0];
  assign dp_out  = OE ? sh_y : 8'h00;

  always @(posedge clk) if (WE) rf[WA] <= IE ? in_bus : sh_y;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] prod;
    int         cycles;
    int         adds;
  } exp_t;
  exp_t sb[$];
  int   seq[$];

  logic [17:0] cw_obs;
  assign cw_obs = {IE, WE, WA, RAE, RAA, RBE, RBA, ALU, SH, OE, busy, done};

  function automatic logic [17:0] mk(input logic ie, we, input logic [1:0] wa,
                                     input logic rae, input logic [1:0] raa,
                                     input logic rbe, input logic [1:0] rba,
                                     input logic [2:0] alu, input logic [1:0] sh,
                                     input logic oe, bsy, dn);
    return {ie, we, wa, rae, raa, rbe, rba, alu, sh, oe, bsy, dn};
  endfunction

  function automatic logic [17:0] exp_cw(input int s);
    case (s)
      S_LDA:   return mk(1, 1, 0, 0, 0, 0, 0, 3'b000, 2'b00, 0, 1, 0);
      S_LDB:   return mk(1, 1, 1, 0, 0, 0, 0, 3'b000, 2'b00, 0, 1, 0);
      S_CLR:   return mk(0, 1, 2, 1, 2, 1, 2, 3'b101, 2'b00, 0, 1, 0);
      S_TEST:  return mk(0, 0, 0, 1, 1, 0, 0, 3'b000, 2'b00, 0, 1, 0);
      S_ADD:   return mk(0, 1, 2, 1, 2, 1, 0, 3'b001, 2'b00, 0, 1, 0);
      S_SHA:   return mk(0, 1, 0, 1, 0, 0, 0, 3'b000, 2'b01, 0, 1, 0);
      S_SHB:   return mk(0, 1, 1, 1, 1, 0, 0, 3'b000, 2'b10, 0, 1, 0);
      S_DONE:  return mk(0, 0, 0, 1, 2, 0, 0, 3'b000, 2'b00, 1, 0, 1);
      default: return 18'h0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full multiply: drive start, follow every state, then score the result
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input bit hold_restart);
    exp_t       e;
    logic [7:0] bb;
    int         edges, adds, n_add;
    bit         done_seen;
    seq.delete();
    seq.push_back(S_LDA); seq.push_back(S_LDB); seq.push_back(S_CLR);
    bb = b;
    n_add = 0;
    for (int it = 0; it < WIDTH; it++) begin
      seq.push_back(S_TEST);
      if (bb[0]) begin seq.push_back(S_ADD); n_add++; end
      seq.push_back(S_SHA);
      seq.push_back(S_SHB);
      bb = bb >> 1;
      if (EARLY && bb == 8'h00) break;
    end
    seq.push_back(S_DONE);
    e.prod = 8'(a * b);
    e.cycles = seq.size();
    e.adds = n_add;
    sb.push_back(e);

    op_a = a;
    op_b = b;
    @(negedge clk);
    start = 1'b1;
    restart = hold_restart;
    edges = 0;
    adds = 0;
    done_seen = 0;
    while (!done_seen && edges < 100) begin
      @(negedge clk);
      start = 1'b0;
      edges++;
      if (edges <= seq.size())
        checkOutput($sformatf("cw@edge%0d", edges), 32'(cw_obs), 32'(exp_cw(seq[edges-1])));
      if (cw_obs === exp_cw(S_ADD)) adds++;
      if (done === 1'b1) done_seen = 1;
    end
    restart = 1'b0;
    if (!done_seen) checkOutput("done_timeout", 32'(done), 32'd1);

    e = sb.pop_front();
    checkOutput($sformatf("latency a=%0h b=%0h", a, b), 32'(edges), 32'(e.cycles));
    checkOutput($sformatf("product a=%0h b=%0h", a, b), 32'(dp_out), 32'(e.prod));
    checkOutput("add_visits", 32'(adds), 32'(e.adds));

    // start must not disturb DONE; restart then returns to IDLE
    start = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("start_in_done", 32'(cw_obs), 32'(exp_cw(S_DONE)));
    end
    start = 1'b0;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    checkOutput("restart_to_idle", 32'(cw_obs), 32'(exp_cw(S_IDLE)));
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    start = 1'b0;
    restart = 1'b0;
    op_a = 8'h00;
    op_b = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("reset_cw", 32'(cw_obs), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_hold", 32'(cw_obs), 32'd0);

    applyStimulus(8'd3, 8'd5, 1'b1);
    applyStimulus(8'd3, 8'd5, 1'b0);
    applyStimulus(8'hFF, 8'hFF, 1'b0);
    applyStimulus(8'h2A, 8'h00, 1'b0);
    applyStimulus(8'h00, 8'h9C, 1'b0);
    applyStimulus(8'h81, 8'h80, 1'b0);
    applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
    applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);

    // Abort mid-loop from ADD with synchronous reset
    op_a = 8'd3;
    op_b = 8'd5;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (cw_obs !== exp_cw(S_ADD) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("reach_add", 32'(cw_obs), 32'(exp_cw(S_ADD)));
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset_in_add", 32'(cw_obs), 32'd0);
    @(negedge clk);
    checkOutput("reset_held", 32'(cw_obs), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_after_reset", 32'(cw_obs), 32'd0);

    applyStimulus(8'd6, 8'd7, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
